// File: rtl/ysyx_25020047_pkg.sv
// Shared constants for the IFU/LSU memory arbiter: FSM state encoding and owner ids.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ysyx_25020047_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Owner / last-grant identifiers; also the bit index in req/gnt vectors
    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25020047_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the unit not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies req with its own availability.
// Ports: req[1:0] (bit0 = IFU, bit1 = LSU), last (previous winner), gnt[1:0] one-hot or zero.
module ysyx_25020047_rr_arb2
    import ysyx_25020047_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Tie: favour whoever did not win the previous arbitration
            2'b11:   gnt = (last == OWNER_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_mem_arbiter.sv
// Shares one single-port memory between IFU (read-only) and LSU (read/write), one transaction at a time.
// Latency: request accept -> resp_valid pulse is 3 cycles with a zero-wait memory (more if memory stalls).
// Backpressure: *_req_ready only in IDLE; mem_req_ready=0 holds the latched request stable in ISSUE.
// Ports: clock/reset (sync, active-high); ifu_* fetch port; lsu_* load/store port;
//        mem_* single-port memory bridge; responses return as one-cycle pulses to the issuing unit.
module ysyx_25020047_mem_arbiter
    import ysyx_25020047_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // IFU
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    // LSU
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    // Memory bridge
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    logic [1:0]          state_q,          state_d;
    logic                owner_q,          owner_d;
    logic                last_q,           last_d;
    logic [ADDR_W-1:0]   addr_q,           addr_d;
    logic                wen_q,            wen_d;
    logic [DATA_W-1:0]   wdata_q,          wdata_d;
    logic [MASK_W-1:0]   wmask_q,          wmask_d;
    logic                ifu_resp_valid_q, ifu_resp_valid_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DATA_W-1:0]   ifu_rdata_q,      ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q,      lsu_rdata_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       idle;

    assign idle    = (state_q == ST_IDLE);
    // Requests are only considered in IDLE, which spaces grants by a whole transaction
    assign arb_req = idle ? {lsu_req_valid, ifu_req_valid} : 2'b00;

    ysyx_25020047_rr_arb2 u_rr_arb2 (
        .req  (arb_req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // A handshake during reset would be dropped by the flops, so do not advertise it
    assign ifu_req_ready = arb_gnt[OWNER_IFU] & ~reset;
    assign lsu_req_ready = arb_gnt[OWNER_LSU] & ~reset;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_d           = last_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;
        ifu_rdata_d      = ifu_rdata_q;
        lsu_rdata_d      = lsu_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_gnt[OWNER_LSU]) begin
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    // Loads must present an all-zero mask to the memory
                    wmask_d = lsu_wen ? lsu_wmask : '0;
                    owner_d = OWNER_LSU;
                    last_d  = OWNER_LSU;
                    state_d = ST_ISSUE;
                end else if (arb_gnt[OWNER_IFU]) begin
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = OWNER_IFU;
                    last_d  = OWNER_IFU;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Responses in IDLE/ISSUE never reach this branch, so they are dropped
                if (mem_resp_valid) begin
                    if (owner_q == OWNER_LSU) begin
                        lsu_rdata_d      = mem_rdata;
                        lsu_resp_valid_d = 1'b1;
                    end else begin
                        ifu_rdata_d      = mem_rdata;
                        ifu_resp_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            owner_q          <= OWNER_IFU;
            last_q           <= OWNER_IFU;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_q           <= last_d;
            addr_q           <= addr_d;
            wen_q            <= wen_d;
            wdata_q          <= wdata_d;
            wmask_q          <= wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
        end
    end

    // Memory side is driven only from the latched request
    assign mem_req_valid  = (state_q == ST_ISSUE);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios then random traffic against a transaction model.
// Latency: n/a.
// Backpressure: the bench memory randomly stalls mem_req_ready and delays responses by 1..3 cycles.
module tb_ysyx_25020047_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clock = ~clock;

    ysyx_25020047_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: 0 = free, 1 = request pending at memory, 2 = awaiting data
    int          phase;
    bit          m_last;
    bit          m_owner;
    logic [31:0] m_addr, m_wdata;
    bit          m_wen;
    logic [3:0]  m_wmask;
    bit          e_ifu_pulse, e_lsu_pulse;
    logic [31:0] e_ifu_rdata, e_lsu_rdata;
    int          grant_log[$];

    // Bench memory
    logic [31:0] mem_words [logic [29:0]];
    int          resp_cnt;
    int          resp_dly;
    logic [31:0] resp_data;
    bit          spurious;
    bit          ovr_en;
    logic [31:0] ovr_data;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_words.exists(a[31:2])) return mem_words[a[31:2]];
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // One clock cycle: inputs are already applied (posedge+1); check at negedge, advance model at posedge.
    task automatic step();
        bit g_ifu, g_lsu;
        logic [31:0] w;
        mem_resp_valid = (resp_cnt == 1) || spurious;
        mem_rdata      = (resp_cnt == 1) ? resp_data : $urandom;
        g_ifu = 1'b0;
        g_lsu = 1'b0;
        if (phase == 0 && !reset) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (m_last) g_ifu = 1'b1;
                else        g_lsu = 1'b1;
            end else begin
                g_ifu = ifu_req_valid;
                g_lsu = lsu_req_valid;
            end
        end
        @(negedge clock);
        if (!reset) begin
            chk("ifu_req_ready", ifu_req_ready, g_ifu);
            chk("lsu_req_ready", lsu_req_ready, g_lsu);
            chk("mem_req_valid", mem_req_valid, phase == 1);
            if (phase == 1) begin
                chk("mem_addr",  mem_addr,  m_addr);
                chk("mem_wen",   mem_wen,   m_wen);
                chk("mem_wmask", mem_wmask, m_wmask);
                if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("ifu_resp_valid", ifu_resp_valid, e_ifu_pulse);
            chk("lsu_resp_valid", lsu_resp_valid, e_lsu_pulse);
            chk("ifu_rdata", ifu_rdata, e_ifu_rdata);
            chk("lsu_rdata", lsu_rdata, e_lsu_rdata);
            if (ifu_req_ready) grant_log.push_back(0);
            if (lsu_req_ready) grant_log.push_back(1);
        end
        @(posedge clock);
        if (reset) begin
            phase       = 0;
            m_last      = 1'b0;
            e_ifu_pulse = 1'b0;
            e_lsu_pulse = 1'b0;
            e_ifu_rdata = '0;
            e_lsu_rdata = '0;
            resp_cnt    = 0;
        end else begin
            e_ifu_pulse = 1'b0;
            e_lsu_pulse = 1'b0;
            if (phase == 2 && mem_resp_valid) begin
                if (m_owner) begin
                    e_lsu_pulse = 1'b1;
                    e_lsu_rdata = mem_rdata;
                end else begin
                    e_ifu_pulse = 1'b1;
                    e_ifu_rdata = mem_rdata;
                end
                phase = 0;
            end else if (phase == 1 && mem_req_ready) begin
                phase = 2;
            end else if (phase == 0 && (g_ifu || g_lsu)) begin
                m_owner = g_lsu;
                m_last  = g_lsu;
                m_addr  = g_lsu ? lsu_addr : ifu_addr;
                m_wen   = g_lsu ? lsu_wen : 1'b0;
                m_wdata = lsu_wdata;
                m_wmask = (g_lsu && lsu_wen) ? lsu_wmask : 4'h0;
                phase   = 1;
            end
            // Memory acts on what the DUT actually presents
            if (mem_req_valid && mem_req_ready) begin
                if (mem_wen) begin
                    w = mem_read(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_wmask[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    mem_words[mem_addr[31:2]] = w;
                    resp_data = $urandom;
                end else begin
                    resp_data = mem_read(mem_addr);
                end
                if (ovr_en) resp_data = ovr_data;
                resp_cnt = resp_dly + 1;
            end
            if (resp_cnt > 0) resp_cnt--;
        end
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        spurious      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0;
        phase = 0; m_last = 1'b0; m_owner = 1'b0; m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wmask = '0;
        e_ifu_pulse = 1'b0; e_lsu_pulse = 1'b0; e_ifu_rdata = '0; e_lsu_rdata = '0;
        resp_cnt = 0; resp_dly = 1; resp_data = '0; spurious = 1'b0; ovr_en = 1'b0; ovr_data = '0;
        #1;
        step();
        step();
        // Reset state: every output low
        @(negedge clock);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr",  mem_addr,  32'h0);
        chk("rst_mem_wen",   mem_wen,   1'b0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", mem_wmask, 4'h0);
        chk("rst_ifu_resp",  ifu_resp_valid, 1'b0);
        chk("rst_lsu_resp",  lsu_resp_valid, 1'b0);
        chk("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk("rst_lsu_rdata", lsu_rdata, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 1. IFU fetch, zero-wait memory, response at +3
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        ovr_en = 1'b1; ovr_data = 32'h0000_0413; resp_dly = 1;
        step();
        ifu_req_valid = 1'b0;
        step();
        step();
        step();
        chk("t1_ifu_rdata_held", ifu_rdata, 32'h0000_0413);
        chk("t1_lsu_resp", lsu_resp_valid, 1'b0);
        ovr_en = 1'b0;

        // 2. LSU store passes through exactly
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1002; lsu_wen = 1'b1;
        lsu_wdata = 32'hBEEF_0000; lsu_wmask = 4'b1100;
        step();
        lsu_req_valid = 1'b0;
        repeat (3) step();
        chk("t2_store_word", mem_read(32'h8000_1000) & 32'hFFFF_0000, 32'hBEEF_0000);

        // 3. Both requesting from reset: LSU, IFU, LSU, IFU
        reset = 1'b1;
        step();
        reset = 1'b0;
        grant_log.delete();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ifu_addr = $urandom; lsu_addr = $urandom;
            step();
        end
        idle_inputs();
        step();
        chk("t3_grant_count", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            chk("t3_grant0", grant_log[0], 1);
            chk("t3_grant1", grant_log[1], 0);
            chk("t3_grant2", grant_log[2], 1);
            chk("t3_grant3", grant_log[3], 0);
        end

        // 4. Memory stalls in ISSUE while the IFU address keeps moving
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifu_addr = $urandom;
            step();
        end
        chk("t4_mem_addr_latched", mem_addr, 32'h8000_0040);
        mem_req_ready = 1'b1;
        ifu_req_valid = 1'b0;
        repeat (3) step();

        // 5. Reset during WAIT abandons the request; late response is ignored
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080; resp_dly = 3;
        step();
        ifu_req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        spurious = 1'b1;
        step();
        spurious = 1'b0;
        step();
        chk("t5_ifu_rdata_cleared", ifu_rdata, 32'h0);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0084; resp_dly = 1;
        step();
        ifu_req_valid = 1'b0;
        repeat (3) step();

        // 6. Spurious memory response while idle
        spurious = 1'b1;
        repeat (2) step();
        spurious = 1'b0;
        step();

        // Random traffic with memory stalls and variable response delay
        for (int i = 0; i < 1500; i++) begin
            ifu_req_valid = $urandom_range(0, 1);
            lsu_req_valid = $urandom_range(0, 1);
            ifu_addr      = $urandom;
            lsu_addr      = {$urandom_range(0, 15), 28'h0} | ($urandom & 32'h3F);
            lsu_wen       = $urandom_range(0, 1);
            lsu_wdata     = $urandom;
            lsu_wmask     = $urandom;
            mem_req_ready = ($urandom_range(0, 3) != 0);
            resp_dly      = $urandom_range(1, 3);
            spurious      = (phase != 2) && (resp_cnt == 0) && ($urandom_range(0, 7) == 0);
            step();
        end
        idle_inputs();
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
